// File: rtl/rb_saxi_capture.sv
// Stream sink for the oscillator sample outputs: optional decimation into a
// block-RAM FIFO that software drains through a small register window.
module rb_saxi_capture #(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic                 clk_adc_125mhz,
  input  logic                 adc_rstn_i,
  input  logic                 s_vld,
  input  logic signed [DW-1:0] s_dat,
  input  logic [31:0]          sys_addr,
  input  logic [31:0]          sys_wdata,
  input  logic [3:0]           sys_sel,
  input  logic                 sys_wen,
  input  logic                 sys_ren,
  output logic [31:0]          sys_rdata,
  output logic                 sys_err,
  output logic                 sys_ack,
  output logic                 irq_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam logic [AW:0]   DEPTH_M1 = {1'b0, {AW{1'b1}}};
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] ADR_ONE  = AW'(1);

  function automatic logic [31:0] sext32(input logic signed [DW-1:0] v);
    return 32'(v);
  endfunction

  state_t               state_r, state_nxt;
  logic                 en_r, single_r, ovf_r, udf_r;
  logic [15:0]          decim_r, dcnt_r;
  logic [31:0]          total_r;
  logic [AW:0]          wptr_r, rptr_r, fill;
  logic [2:0]           reg_sel;
  logic                 wr_ctrl, wr_decim, rd_pop_req, clr;
  logic                 empty, full, push_req, push, pop, drop, fill_done;
  logic [AW-1:0]        rd_addr;
  logic signed [DW-1:0] mem [2**AW];
  logic signed [DW-1:0] head_p1;
  logic [31:0]          status, rdata_mux;
  logic                 unused_bits;

  assign reg_sel    = sys_addr[4:2];
  assign wr_ctrl    = sys_wen && (reg_sel == 3'd0);
  assign wr_decim   = sys_wen && (reg_sel == 3'd2);
  assign rd_pop_req = sys_ren && (reg_sel == 3'd3);
  assign clr        = wr_ctrl && sys_wdata[2];

  assign fill  = wptr_r - rptr_r;
  assign empty = (wptr_r == rptr_r);
  assign full  = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);

  // A simultaneous pop frees a slot, so a push into a full FIFO is still accepted.
  assign push_req  = s_vld && (state_r == ST_CAPTURE) && (dcnt_r == 16'd0);
  assign pop       = rd_pop_req && !empty;
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;
  assign fill_done = push && (pop ? full : (fill == DEPTH_M1));

  // Prefetch: look one entry ahead on a pop so the head register is ready next time.
  assign rd_addr = pop ? rptr_r[AW-1:0] + ADR_ONE : rptr_r[AW-1:0];

  assign sys_err     = 1'b0;
  assign irq_o       = (state_r == ST_DONE);
  assign unused_bits = ^{sys_sel, sys_addr[31:5], sys_addr[1:0], sys_wdata[31:16]};

  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE:    if (wr_ctrl && sys_wdata[0]) state_nxt = ST_CAPTURE;
      ST_CAPTURE: begin
        if (wr_ctrl && !sys_wdata[0])            state_nxt = ST_IDLE;
        else if (!clr && single_r && fill_done)  state_nxt = ST_DONE;
      end
      ST_DONE:    if (wr_ctrl && (!sys_wdata[0] || sys_wdata[2])) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    status             = '0;
    status[0]          = empty;
    status[1]          = full;
    status[2]          = ovf_r;
    status[3]          = udf_r;
    status[5:4]        = state_r;
    status[AW+16:16]   = fill;
  end

  always_comb begin
    rdata_mux = '0;
    case (reg_sel)
      3'd0:    rdata_mux = {30'd0, single_r, en_r};
      3'd1:    rdata_mux = status;
      3'd2:    rdata_mux = {16'd0, decim_r};
      3'd3:    rdata_mux = empty ? 32'd0 : sext32(head_p1);
      3'd4:    rdata_mux = total_r;
      default: rdata_mux = '0;
    endcase
  end

  // Control and bus response stage
  always_ff @(posedge clk_adc_125mhz) begin
    if (!adc_rstn_i) begin
      state_r   <= ST_IDLE;
      en_r      <= 1'b0;
      single_r  <= 1'b0;
      decim_r   <= '0;
      dcnt_r    <= '0;
      wptr_r    <= '0;
      rptr_r    <= '0;
      total_r   <= '0;
      ovf_r     <= 1'b0;
      udf_r     <= 1'b0;
      sys_ack   <= 1'b0;
      sys_rdata <= '0;
    end else begin
      state_r <= state_nxt;
      if (wr_ctrl) begin
        en_r     <= sys_wdata[0];
        single_r <= sys_wdata[1];
      end
      if (wr_decim) decim_r <= sys_wdata[15:0];

      if (wr_decim || (state_r == ST_IDLE && state_nxt == ST_CAPTURE))
        dcnt_r <= '0;
      else if (s_vld && state_r == ST_CAPTURE)
        dcnt_r <= (dcnt_r == decim_r) ? 16'd0 : dcnt_r + 16'd1;

      if (clr) begin
        wptr_r  <= '0;
        rptr_r  <= '0;
        total_r <= '0;
        ovf_r   <= 1'b0;
        udf_r   <= 1'b0;
      end else begin
        if (push) begin
          wptr_r  <= wptr_r + PTR_ONE;
          total_r <= total_r + 32'd1;
        end
        if (pop)                 rptr_r <= rptr_r + PTR_ONE;
        if (drop)                ovf_r  <= 1'b1;
        if (rd_pop_req && empty) udf_r  <= 1'b1;
      end

      sys_ack   <= sys_wen || sys_ren;
      sys_rdata <= sys_ren ? rdata_mux : 32'd0;
    end
  end

  // Sample storage and head prefetch stage
  always_ff @(posedge clk_adc_125mhz) begin
    if (push) mem[wptr_r[AW-1:0]] <= s_dat;
    head_p1 <= mem[rd_addr];
  end

endmodule

// File: tb/tb_rb_saxi_capture.sv
// Self-checking bench for rb_saxi_capture against a queue-based register model.
module tb_rb_saxi_capture;
  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk_adc_125mhz = 1'b0;
  logic          adc_rstn_i = 1'b0;
  logic          s_vld = 1'b0;
  logic [DW-1:0] s_dat = '0;
  logic [31:0]   sys_addr = '0;
  logic [31:0]   sys_wdata = '0;
  logic [3:0]    sys_sel = 4'hF;
  logic          sys_wen = 1'b0;
  logic          sys_ren = 1'b0;
  logic [31:0]   sys_rdata;
  logic          sys_err, sys_ack, irq_o;

  always #4 clk_adc_125mhz = ~clk_adc_125mhz;

  rb_saxi_capture #(.DW(DW), .AW(AW)) dut (
    .clk_adc_125mhz(clk_adc_125mhz),
    .adc_rstn_i    (adc_rstn_i),
    .s_vld         (s_vld),
    .s_dat         (s_dat),
    .sys_addr      (sys_addr),
    .sys_wdata     (sys_wdata),
    .sys_sel       (sys_sel),
    .sys_wen       (sys_wen),
    .sys_ren       (sys_ren),
    .sys_rdata     (sys_rdata),
    .sys_err       (sys_err),
    .sys_ack       (sys_ack),
    .irq_o         (irq_o)
  );

  // Reference model: sample queue plus register/state variables.
  logic [DW-1:0] mq[$];
  int            mstate, mdecim, mdcnt;
  bit            men, msingle, movf, mudf;
  logic [31:0]   mtotal;
  logic          irq_ack;
  int            n_run = 0;
  int            n_fail = 0;

  task automatic m_reset();
    mq.delete();
    mstate = 0; mdecim = 0; mdcnt = 0;
    men = 0; msingle = 0; movf = 0; mudf = 0;
    mtotal = '0;
  endtask

  function automatic logic [31:0] m_status();
    return (32'(mq.size()) << 16) | (32'(mstate) << 4) |
           {28'd0, mudf, movf, mq.size() == DEPTH, mq.size() == 0};
  endfunction

  task automatic m_cycle(input bit wen, input bit ren, input logic [31:0] addr,
                         input logic [31:0] wd, input bit vld, input logic [DW-1:0] dat,
                         output logic [31:0] exp);
    int a;
    a = int'(addr[4:2]);
    exp = '0;
    if (ren) begin
      case (a)
        0: exp = {30'd0, msingle, men};
        1: exp = m_status();
        2: exp = 32'(mdecim);
        3: exp = (mq.size() == 0) ? 32'd0 : 32'($signed(mq[0]));
        4: exp = mtotal;
        default: exp = '0;
      endcase
    end
    if (ren && a == 3) begin
      if (mq.size() == 0) mudf = 1;
      else void'(mq.pop_front());
    end
    if (vld && mstate == 1) begin
      if (mdcnt == 0) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(dat);
          mtotal = mtotal + 1;
          if (msingle && mq.size() == DEPTH) mstate = 2;
        end else begin
          movf = 1;
        end
      end
      mdcnt = (mdcnt >= mdecim) ? 0 : mdcnt + 1;
    end
    if (wen && a == 0) begin
      if (wd[2]) begin
        mq.delete(); mtotal = '0; movf = 0; mudf = 0;
      end
      case (mstate)
        0:       if (wd[0]) begin mstate = 1; mdcnt = 0; end
        1:       if (!wd[0]) mstate = 0;
        default: if (!wd[0] || wd[2]) mstate = 0;
      endcase
      men = wd[0]; msingle = wd[1];
    end
    if (wen && a == 2) begin
      mdecim = int'(wd[15:0]);
      mdcnt = 0;
    end
  endtask

  // One bus/sample cycle followed by one idle cycle; samples the ack cycle.
  task automatic cyc(input bit wen, input bit ren, input logic [31:0] addr, input logic [31:0] wd,
                     input bit vld, input logic [DW-1:0] dat,
                     output logic [31:0] exp, output logic [31:0] got, output logic ack);
    sys_wen = wen; sys_ren = ren; sys_addr = addr; sys_wdata = wd; s_vld = vld; s_dat = dat;
    m_cycle(wen, ren, addr, wd, vld, dat, exp);
    @(negedge clk_adc_125mhz);
    sys_wen = 1'b0; sys_ren = 1'b0; s_vld = 1'b0;
    got = sys_rdata; ack = sys_ack; irq_ack = irq_o;
    @(negedge clk_adc_125mhz);
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] e, output logic [31:0] g, output logic k);
    cyc(1'b0, 1'b1, addr, 32'd0, 1'b0, '0, e, g, k);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] d, output logic k);
    logic [31:0] e, g;
    cyc(1'b1, 1'b0, addr, d, 1'b0, '0, e, g, k);
  endtask

  task automatic smp(input logic [DW-1:0] d);
    logic [31:0] e, g;
    logic k;
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, d, e, g, k);
  endtask

  task automatic test_reset();
    logic [31:0] e, g;
    logic k;
    adc_rstn_i = 1'b0;
    m_reset();
    repeat (3) @(negedge clk_adc_125mhz);
    n_run++;
    if (sys_ack !== 1'b0 || sys_rdata !== 32'd0 || sys_err !== 1'b0 || irq_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs ack=%b rdata=%h err=%b irq=%b want all 0", sys_ack, sys_rdata, sys_err, irq_o);
    end
    adc_rstn_i = 1'b1;
    rd(32'h00, e, g, k);
    n_run++; if (g !== 32'h0 || k !== 1'b1) begin n_fail++; $display("FAIL reset_ctrl got=%h ack=%b want 0 ack 1", g, k); end
    rd(32'h04, e, g, k);
    n_run++; if (g !== 32'h1 || k !== 1'b1) begin n_fail++; $display("FAIL reset_status got=%h ack=%b want 1 ack 1", g, k); end
    rd(32'h10, e, g, k);
    n_run++; if (g !== 32'h0 || k !== 1'b1) begin n_fail++; $display("FAIL reset_total got=%h ack=%b want 0 ack 1", g, k); end
    rd(32'h08, e, g, k);
    n_run++; if (g !== 32'h0) begin n_fail++; $display("FAIL reset_decim got=%h want 0", g); end
    sys_ren = 1'b1; sys_addr = 32'h04;
    n_run++; if (sys_ack !== 1'b0) begin n_fail++; $display("FAIL ack_early ack=%b want 0", sys_ack); end
    @(negedge clk_adc_125mhz);
    sys_ren = 1'b0;
    n_run++; if (sys_ack !== 1'b1 || sys_rdata !== 32'h1) begin n_fail++; $display("FAIL ack_latency ack=%b rdata=%h want 1/1", sys_ack, sys_rdata); end
    @(negedge clk_adc_125mhz);
    n_run++; if (sys_ack !== 1'b0 || sys_rdata !== 32'h0) begin n_fail++; $display("FAIL ack_drop ack=%b rdata=%h want 0/0", sys_ack, sys_rdata); end
  endtask

  task automatic test_basic();
    logic [31:0] e, g;
    logic k;
    logic [31:0] tab [3];
    tab[0] = 32'hFFFF_8000; tab[1] = 32'h0000_7FFF; tab[2] = 32'h0000_0001;
    wr(32'h00, 32'h1, k);
    n_run++; if (k !== 1'b1) begin n_fail++; $display("FAIL basic_wr_ack ack=%b want 1", k); end
    wr(32'h08, 32'h0, k);
    smp(16'h8000); smp(16'h7FFF); smp(16'h0001);
    for (int i = 0; i < 3; i++) begin
      rd(32'h0C, e, g, k);
      n_run++; if (g !== tab[i]) begin n_fail++; $display("FAIL basic_data%0d got=%h want %h", i, g, tab[i]); end
    end
    rd(32'h10, e, g, k);
    n_run++; if (g !== 32'd3) begin n_fail++; $display("FAIL basic_total got=%0d want 3", g); end
    rd(32'h0C, e, g, k);
    n_run++; if (g !== 32'd0) begin n_fail++; $display("FAIL basic_underflow_data got=%h want 0", g); end
    rd(32'h04, e, g, k);
    n_run++; if (g[3] !== 1'b1 || g !== e) begin n_fail++; $display("FAIL basic_udf got=%h want %h", g, e); end
    wr(32'h00, 32'h4, k);
  endtask

  task automatic test_decim();
    logic [31:0] e, g;
    logic k;
    int n, cnt;
    wr(32'h00, 32'h5, k);
    wr(32'h08, 32'h2, k);
    for (int i = 0; i < 9; i++) begin
      smp(DW'(i));
      repeat ($urandom_range(0, 3)) @(negedge clk_adc_125mhz);
    end
    for (int i = 0; i < 3; i++) begin
      rd(32'h0C, e, g, k);
      n_run++; if (g !== 32'(3 * i)) begin n_fail++; $display("FAIL decim_data%0d got=%h want %h", i, g, 32'(3 * i)); end
    end
    rd(32'h10, e, g, k);
    n_run++; if (g !== 32'd3) begin n_fail++; $display("FAIL decim_total got=%0d want 3", g); end
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(0, 4);
      cnt = $urandom_range(5, 14);
      wr(32'h00, 32'h5, k);
      wr(32'h08, 32'(n), k);
      for (int j = 0; j < cnt; j++) smp(DW'($urandom));
      rd(32'h10, e, g, k);
      n_run++; if (g !== 32'((cnt + n) / (n + 1))) begin n_fail++; $display("FAIL decim_rnd_total n=%0d cnt=%0d got=%0d want %0d", n, cnt, g, (cnt + n) / (n + 1)); end
      while (mq.size() > 0) begin
        rd(32'h0C, e, g, k);
        n_run++; if (g !== e) begin n_fail++; $display("FAIL decim_rnd_data got=%h want %h", g, e); end
      end
    end
  endtask

  task automatic test_single();
    logic [31:0] e, g;
    logic k;
    wr(32'h00, 32'h4, k);
    wr(32'h08, 32'h0, k);
    wr(32'h00, 32'h3, k);
    for (int i = 0; i < 20; i++) begin
      smp(DW'($urandom));
      n_run++; if (irq_ack !== (mstate == 2)) begin n_fail++; $display("FAIL single_irq%0d got=%b want %b", i, irq_ack, mstate == 2); end
    end
    rd(32'h04, e, g, k);
    n_run++; if (g !== 32'h0010_0022 || g !== e) begin n_fail++; $display("FAIL single_status got=%h want 00100022", g); end
    rd(32'h10, e, g, k);
    n_run++; if (g !== 32'd16) begin n_fail++; $display("FAIL single_total got=%0d want 16", g); end
    wr(32'h00, 32'h0, k);
    rd(32'h04, e, g, k);
    n_run++; if (g !== 32'h0010_0002 || irq_o !== 1'b0) begin n_fail++; $display("FAIL single_idle status=%h irq=%b want 00100002/0", g, irq_o); end
    for (int i = 0; i < 4; i++) begin
      rd(32'h0C, e, g, k);
      n_run++; if (g !== e) begin n_fail++; $display("FAIL single_data%0d got=%h want %h", i, g, e); end
    end
  endtask

  task automatic test_continuous();
    logic [31:0] e, g;
    logic k;
    wr(32'h00, 32'h5, k);
    for (int i = 0; i < 20; i++) smp(DW'($urandom));
    rd(32'h04, e, g, k);
    n_run++; if (g !== 32'h0010_0016) begin n_fail++; $display("FAIL cont_status got=%h want 00100016", g); end
    rd(32'h10, e, g, k);
    n_run++; if (g !== 32'd16) begin n_fail++; $display("FAIL cont_total got=%0d want 16", g); end
    cyc(1'b0, 1'b1, 32'h0C, 32'd0, 1'b1, DW'($urandom), e, g, k);
    n_run++; if (g !== e || k !== 1'b1) begin n_fail++; $display("FAIL cont_poppush got=%h want %h", g, e); end
    rd(32'h04, e, g, k);
    n_run++; if (g !== 32'h0010_0016) begin n_fail++; $display("FAIL cont_poppush_status got=%h want 00100016", g); end
    rd(32'h10, e, g, k);
    n_run++; if (g !== 32'd17) begin n_fail++; $display("FAIL cont_poppush_total got=%0d want 17", g); end
    for (int i = 0; i < DEPTH; i++) begin
      rd(32'h0C, e, g, k);
      n_run++; if (g !== e) begin n_fail++; $display("FAIL cont_data%0d got=%h want %h", i, g, e); end
    end
    wr(32'h00, 32'h5, k);
    rd(32'h04, e, g, k);
    n_run++; if (g !== 32'h0000_0011) begin n_fail++; $display("FAIL cont_clr_status got=%h want 00000011", g); end
    rd(32'h10, e, g, k);
    n_run++; if (g !== 32'd0) begin n_fail++; $display("FAIL cont_clr_total got=%0d want 0", g); end
  endtask

  task automatic test_random();
    logic [31:0] e, g, ra;
    logic k;
    int op;
    wr(32'h00, 32'h4, k);
    wr(32'h00, 32'h1, k);
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2: smp(DW'($urandom));
        3: begin
          rd(32'h0C, e, g, k);
          n_run++; if (g !== e) begin n_fail++; $display("FAIL rnd_data op%0d got=%h want %h", i, g, e); end
        end
        4: begin
          cyc(1'b0, 1'b1, 32'h0C, 32'd0, 1'b1, DW'($urandom), e, g, k);
          n_run++; if (g !== e) begin n_fail++; $display("FAIL rnd_poppush op%0d got=%h want %h", i, g, e); end
        end
        5: begin
          rd(32'h04, e, g, k);
          n_run++; if (g !== e) begin n_fail++; $display("FAIL rnd_status op%0d got=%h want %h", i, g, e); end
        end
        6: begin
          rd(32'h10, e, g, k);
          n_run++; if (g !== e) begin n_fail++; $display("FAIL rnd_total op%0d got=%h want %h", i, g, e); end
        end
        7: begin
          wr(32'h00, {29'd0, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0}, k);
          n_run++; if (k !== 1'b1) begin n_fail++; $display("FAIL rnd_wr_ack op%0d ack=%b want 1", i, k); end
        end
        8: wr(32'h08, 32'($urandom_range(0, 3)), k);
        default: begin
          case ($urandom_range(0, 4))
            0: ra = 32'h00;
            1: ra = 32'h08;
            2: ra = 32'h14;
            3: ra = 32'h18;
            default: ra = 32'h1C;
          endcase
          rd(ra, e, g, k);
          n_run++; if (g !== e || k !== 1'b1) begin n_fail++; $display("FAIL rnd_reg op%0d addr=%h got=%h ack=%b want %h", i, ra, g, k, e); end
        end
      endcase
      n_run++; if (irq_o !== (mstate == 2)) begin n_fail++; $display("FAIL rnd_irq op%0d got=%b want %b", i, irq_o, mstate == 2); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e, g;
    logic k;
    wr(32'h00, 32'h4, k);
    wr(32'h08, 32'h0, k);
    wr(32'h00, 32'h1, k);
    for (int i = 0; i < 5; i++) smp(DW'($urandom));
    wr(32'h08, 32'h3, k);
    sys_ren = 1'b1; sys_addr = 32'h0C; adc_rstn_i = 1'b0;
    @(negedge clk_adc_125mhz);
    sys_ren = 1'b0; adc_rstn_i = 1'b1;
    m_reset();
    n_run++; if (sys_ack !== 1'b0 || sys_rdata !== 32'd0) begin n_fail++; $display("FAIL rstmid_ack ack=%b rdata=%h want 0/0", sys_ack, sys_rdata); end
    @(negedge clk_adc_125mhz);
    rd(32'h00, e, g, k);
    n_run++; if (g !== 32'h0) begin n_fail++; $display("FAIL rstmid_ctrl got=%h want 0", g); end
    rd(32'h04, e, g, k);
    n_run++; if (g !== 32'h1) begin n_fail++; $display("FAIL rstmid_status got=%h want 1", g); end
    rd(32'h08, e, g, k);
    n_run++; if (g !== 32'h0) begin n_fail++; $display("FAIL rstmid_decim got=%h want 0", g); end
    rd(32'h10, e, g, k);
    n_run++; if (g !== 32'h0 || irq_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_total got=%h irq=%b want 0/0", g, irq_o); end
    smp(DW'($urandom));
    rd(32'h04, e, g, k);
    n_run++; if (g !== 32'h1) begin n_fail++; $display("FAIL rstmid_idle_capture got=%h want 1", g); end
  endtask

  initial begin
    @(negedge clk_adc_125mhz);
    test_reset();
    test_basic();
    test_decim();
    test_single();
    test_continuous();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rb_saxi_capture.md
# rb_saxi_capture

Stream sink for the RadioBox oscillator sample outputs (`osc1_saxi_m_vld`/`osc1_saxi_m_dat` or the OSC2 equivalents). It optionally decimates the incoming valid/data stream and buffers the samples in an internal FIFO. Software drains the FIFO over the system bus through a small register window. The block sits beside `red_pitaya_radiobox` on the 125 MHz ADC clock domain and is the receiving end of its sample stream.

## Interface
Parameters:
- `DW`, 16, sample width of the input stream.
- `AW`, 10, FIFO depth is 2**AW samples.

Ports:
- `clk_adc_125mhz`  in  1  single clock for all logic.
- `adc_rstn_i`  in  1  reset, synchronous, active-low.
- `s_vld`  in  1  input sample valid; a sample is taken in any cycle where this is high (no backpressure).
- `s_dat`  in  DW  input sample, two's complement.
- `sys_addr`  in  32  bus address; only bits [4:2] are decoded.
- `sys_wdata`  in  32  bus write data.
- `sys_sel`  in  4  byte select; ignored, writes are always full-word.
- `sys_wen`  in  1  write strobe, one cycle.
- `sys_ren`  in  1  read strobe, one cycle.
- `sys_rdata`  out  32  read data, valid with `sys_ack`.
- `sys_err`  out  1  always 0.
- `sys_ack`  out  1  one-cycle acknowledge.
- `irq_o`  out  1  level interrupt, high while the capture state is DONE.

## Operation
Registers (offset, access, field layout):
- 0x00 CTRL, RW.
  - bit0 EN.
  - bit1 SINGLE: 1 = stop when the FIFO is full; 0 = continuous.
  - bit2 CLR: write-1 self-clearing pulse. It empties the FIFO, zeroes TOTAL, and clears the sticky flags. It reads back as 0.
- 0x04 STATUS, RO.
  - bit0 EMPTY, bit1 FULL.
  - bit2 OVF: sticky; set when a sample is dropped because the FIFO is full.
  - bit3 UDF: sticky; set when DATA is read while empty.
  - bits[5:4] state: IDLE=0, CAPTURE=1, DONE=2.
  - bits[AW+16:16] fill level, 0..2**AW.
- 0x08 DECIM, RW, bits[15:0] = N. One sample in N+1 accepted valid samples is stored. N=0 stores every sample.
- 0x0C DATA, RO. A read pops one sample and returns it sign-extended to 32 bits. If the FIFO is empty, the read returns 0, sets UDF, and pointers do not move.
- 0x10 TOTAL, RO. 32-bit count of samples written to the FIFO since the last CLR; wraps at 2**32.
- Unmapped offsets: reads return 0; writes are ignored; `sys_ack` is still given.

State machine:
- IDLE → CAPTURE: EN written to 1. The decimation counter is cleared on this transition.
- CAPTURE → IDLE: EN written to 0. FIFO contents are kept.
- CAPTURE → DONE: SINGLE=1 and a push makes the FIFO full.
- DONE → IDLE: EN written to 0 or CLR=1. Popping does not leave DONE.
- CLR in any state empties the FIFO. CAPTURE stays CAPTURE after CLR; DONE goes to IDLE.
- Samples are pushed only in CAPTURE.

Decimation:
- Counter runs 0..N on each `s_vld` in CAPTURE. A push happens when the counter equals 0, then the counter increments and wraps N→0.
- A DECIM write takes effect immediately and clears the counter.

FIFO rules:
- Push and pop in the same cycle: both occur and the fill level is unchanged. This applies even when the FIFO is full: the pop frees a slot, the push is accepted, and OVF is not set.
- Push while full with no pop: the sample is dropped, OVF is set, TOTAL is unchanged. In continuous mode this only happens at the full boundary.
- Pointers are AW+1 bits; FULL/EMPTY come from MSB comparison. They wrap naturally.

## Timing
- Reset values:
  - `sys_rdata`=0, `sys_ack`=0, `sys_err`=0, `irq_o`=0.
  - CTRL=0, DECIM=0, TOTAL=0, FIFO empty, OVF/UDF=0, state IDLE.
- Bus latency:
  - `sys_ack` and `sys_rdata` are registered and appear exactly one cycle after `sys_wen`/`sys_ren`.
  - `sys_rdata` returns to 0 when `sys_ack` is low.
  - `sys_wen` and `sys_ren` are never asserted together.
- Write effect: register writes take effect on the cycle of `sys_ack`. A sample with `s_vld` high in the same cycle as the EN=1 write is not captured.
- Read effect: a DATA pop updates the fill level in the ack cycle. A STATUS read returns the value registered in the `sys_ren` cycle.
- Push latency: a sample with `s_vld` at cycle t is readable by a DATA read whose `sys_ren` is at t+2 or later. FIFO memory is inferred block RAM with a registered read; the read data is prefetched.
- `irq_o` rises in the cycle after the push that fills the FIFO.
- Reset mid-operation: all state returns to reset values in the cycle after `adc_rstn_i` is sampled low. Any bus access in progress is not acked.

## Test plan
- Reset, then read 0x00/0x04/0x10 → 0x0, 0x1 (EMPTY, IDLE), 0x0; each ack arrives 1 cycle after `sys_ren`.
- EN=1, DECIM=0, drive `s_vld` with `s_dat`=0x8000, 0x7FFF, 0x0001 → DATA reads return 0xFFFF8000, 0x00007FFF, 0x00000001; TOTAL=3; fourth DATA read → 0 with STATUS.UDF=1.
- DECIM=2, drive 9 valid samples 0..8 with gaps → FIFO holds 0, 3, 6; TOTAL=3.
- AW=4, SINGLE=1, stream 20 samples → fill=16, STATUS state=DONE, `irq_o`=1, OVF=0 (no push attempted after DONE). Write CTRL=0 → IDLE, `irq_o`=0.
- AW=4, continuous, stream 20 samples with no reads → fill=16, OVF=1, TOTAL=16. Then pop and push in the same cycle while full → fill stays 16, TOTAL=17, no new OVF. Then CLR → EMPTY, TOTAL=0, OVF=0.
- Assert `adc_rstn_i`=0 for 1 cycle while 5 samples are buffered and a read is pending → no ack; all registers at reset values.
